tally_uart_tx: RTL

Reads the four 10-bit candidate tallies and serializes them off-chip as a fixed UART 8N1 report frame.
- Report is requested by a single-cycle pulse, typically issued when the machine is in display mode.
- Sits downstream of the vote counter and drives the board's serial TX pin.
- Tallies are snapshotted at request time, so votes landing mid-report never corrupt a frame.

---
 rtl/tally_pkg.sv | 24 ++
 rtl/uart_tx_byte.sv | 114 +++++++++++
 rtl/tally_uart_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tally_pkg.sv
// Shared constants and FSM state encoding for the tally UART report transmitter.
// TALLY_CHECKSUM_EN appends an XOR checksum byte to every report.
package tally_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         NUM_CAND  = 4;

`ifdef TALLY_CHECKSUM_EN
  localparam int REPORT_BYTES = 10;
`else
  localparam int REPORT_BYTES = 9;
`endif

  // START/DATA/STOP belong to the byte serializer; SEND/DONE to the report sequencer.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_SEND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte: start bit, 8 data bits LSB first, stop bit.
// ready rises during the final stop-bit cycle so a new byte can follow with no gap.
module uart_tx_byte
  import tally_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int             TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_r, tx_nx;
  logic          bit_end;

  assign bit_end = (timer == T_LAST);
  assign ready   = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
  assign tx      = tx_r;

  // Next-state and next-output logic for the bit sequencing.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    bit_nx   = bit_idx;
    shift_nx = shift;
    tx_nx    = tx_r;

    if (state == ST_IDLE) begin
      timer_nx = '0;
    end else if (bit_end) begin
      timer_nx = '0;
    end else begin
      timer_nx = timer + TW'(1);
    end

    case (state)
      ST_IDLE: begin
        tx_nx = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_nx = ST_DATA;
          bit_nx   = 3'd0;
          tx_nx    = shift[0];
        end else begin
          tx_nx = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
          state_nx = ST_STOP;
          tx_nx    = 1'b1;
        end else if (bit_end) begin
          bit_nx   = bit_idx + 3'd1;
          shift_nx = {1'b0, shift[7:1]};
          tx_nx    = shift[1];
        end else begin
          tx_nx = tx_r;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_STOP;
        end
        tx_nx = 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
        tx_nx    = 1'b1;
      end
    endcase

    // Accepting here while the stop bit ends keeps consecutive bytes back-to-back.
    if (ready && start) begin
      state_nx = ST_START;
      timer_nx = '0;
      bit_nx   = 3'd0;
      shift_nx = data;
      tx_nx    = 1'b0;
    end else begin
      shift_nx = shift_nx;
    end
  end

  // State and datapath registers; tx idles high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_idx <= bit_nx;
      shift   <= shift_nx;
      tx_r    <= tx_nx;
    end
  end

endmodule

// File: rtl/tally_uart_tx.sv
// Snapshots four 10-bit tallies on report_req and sends them as a sync-led 8N1 report.
// TALLY_CHECKSUM_EN adds a trailing byte equal to the XOR of all preceding bytes.
module tally_uart_tx
  import tally_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       report_req,
  input  logic [9:0] cand1_votes,
  input  logic [9:0] cand2_votes,
  input  logic [9:0] cand3_votes,
  input  logic [9:0] cand4_votes,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_t     state, state_nx;
  logic [9:0] snap [NUM_CAND];
  logic [3:0] byte_idx;
  logic [2:0] idx_m1;
  logic [1:0] cand_sel;
  logic [7:0] byte_val, ser_data;
  logic       ser_start, ser_ready;
  logic       accept, issue, finish;
  logic       busy_r, done_r;
`ifdef TALLY_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign busy = busy_r;
  assign done = done_r;

  // Byte k>=1 maps to candidate (k-1)/2; odd k carries the ID and vote bits [9:8].
  always_comb begin
    idx_m1   = 3'(byte_idx - 4'd1);
    cand_sel = idx_m1[2:1];
    if (idx_m1[0]) begin
      byte_val = snap[cand_sel][7:0];
    end else begin
      byte_val = {cand_sel, 4'b0000, snap[cand_sel][9:8]};
    end
`ifdef TALLY_CHECKSUM_EN
    if (byte_idx == 4'(REPORT_BYTES - 1)) begin
      byte_val = csum;
    end else begin
      byte_val = byte_val;
    end
`endif
  end

  // Report sequencing; the "next byte or finish" step is decided on the stop-bit's last cycle.
  always_comb begin
    state_nx  = state;
    ser_start = 1'b0;
    ser_data  = SYNC_BYTE;
    accept    = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (report_req) begin
          accept    = 1'b1;
          ser_start = 1'b1;
          state_nx  = ST_SEND;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SEND: begin
        ser_data = byte_val;
        if (ser_ready && (byte_idx < 4'(REPORT_BYTES))) begin
          issue     = 1'b1;
          ser_start = 1'b1;
        end else if (ser_ready) begin
          finish   = 1'b1;
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_SEND;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Snapshot, byte index, checksum and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CAND; i++) snap[i] <= 10'd0;
      byte_idx <= 4'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef TALLY_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      done_r <= finish;
      if (accept) begin
        snap[0]  <= cand1_votes;
        snap[1]  <= cand2_votes;
        snap[2]  <= cand3_votes;
        snap[3]  <= cand4_votes;
        byte_idx <= 4'd1;
        busy_r   <= 1'b1;
`ifdef TALLY_CHECKSUM_EN
        csum     <= SYNC_BYTE;
`endif
      end else if (issue) begin
        byte_idx <= byte_idx + 4'd1;
`ifdef TALLY_CHECKSUM_EN
        csum     <= csum ^ byte_val;
`endif
      end else if (finish) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .start(ser_start),
    .data (ser_data),
    .ready(ser_ready),
    .tx   (tx)
  );

endmodule
